// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and helpers for the shift-add multiplier
package alu_pkg;

  // Controller states; IDLE must encode as zero so reset and decode agree.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mult_state_e;

  // Iteration counter width: wide enough to hold DATA_SIZE without wrapping.
  function automatic int cnt_width(input int data_size);
    return $clog2(data_size + 1);
  endfunction

endpackage

// File: rtl/mult_ctrl_fsm.sv
// rtl/mult_ctrl_fsm.sv - sequencing FSM and iteration counter for the multiplier
module mult_ctrl_fsm
  import alu_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic load_o,
  output logic step_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = cnt_width(DATA_SIZE);
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_SIZE - 1);

  mult_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state and counter logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CALC;
          count_d = '0;
        end
      end
      S_CALC: begin
        count_d = count_q + CW'(1);
        if (count_q == LAST_ITER) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Strobes to the datapath and status flags, decoded from the state register.
  always_comb begin
    load_o = (state_q == S_IDLE) && start_i;
    step_o = (state_q == S_CALC);
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-add multiplier datapath
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_SIZE-1:0]   multiplicand,
  input  logic [DATA_SIZE-1:0]   multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*DATA_SIZE-1:0] product
);

  localparam int W = DATA_SIZE;

  logic           load;
  logic           step;
  logic [W-1:0]   a_q, a_d;
  logic [2*W-1:0] p_q, p_d;
  logic [W:0]     sum;

  mult_ctrl_fsm #(
    .DATA_SIZE(DATA_SIZE)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .load_o  (load),
    .step_o  (step),
    .busy_o  (busy),
    .done_o  (done)
  );

  // One iteration: conditional add into the upper half (carry kept), then shift right.
  always_comb begin
    a_d = a_q;
    p_d = p_q;
    sum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, a_q} : '0);
    if (load) begin
      a_d = multiplicand;
      p_d = {{W{1'b0}}, multiplier};
    end else if (step) begin
      p_d = {sum, p_q[W-1:1]};
    end
  end

  // Operand and working registers; cleared on reset so an aborted run leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      p_q <= p_d;
    end
  end

  assign product = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int DS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DS-1:0]   multiplicand;
  logic [DS-1:0]   multiplier;
  logic            busy;
  logic            done;
  logic [2*DS-1:0] product;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_done_cyc = 0;

  shift_add_multiplier #(
    .DATA_SIZE(DS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one multiply and follow it to completion. Entered and left at a negedge.
  task automatic mul(input int a, input int b, input string tag);
    int n;
    int busy_cnt;
    int exp_p;
    logic got_done;
    exp_p = a * b;
    multiplicand = a[DS-1:0];
    multiplier   = b[DS-1:0];
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    busy_cnt = 0;
    got_done = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(DS + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(DS + 1));
    check({tag, "_product"}, 32'(product), 32'(exp_p));
    last_done_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_hold_product"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int first_done;
    int ndone;
    int done_prod;
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);

    mul(13, 11, "basic");
    check("basic_const", 32'(product), 32'h008F);
    mul(255, 255, "max");
    check("max_const", 32'(product), 32'hFE01);
    mul(0, 200, "zero");
    mul(1, 200, "identity");

    // Restarts at cycle 3 and in the DONE cycle must be ignored.
    multiplicand = 8'd7;
    multiplier   = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    done_prod = 0;
    for (int c = 1; c <= 14; c++) begin
      start = (c == 3 || c == 9);
      if (start) begin
        multiplicand = 8'd3;
        multiplier   = 8'd3;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        done_prod = int'(product);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    @(negedge clk);
    check("ignored_done_count", 32'(ndone), 32'd1);
    check("ignored_product", 32'(done_prod), 32'd63);
    check("ignored_busy_after", 32'(busy), 32'd0);
    check("ignored_hold", 32'(product), 32'd63);

    // Reset in the middle of a run clears everything.
    multiplicand = 8'd100;
    multiplier   = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_product", 32'(product), 32'd0);
    mul(2, 3, "after_reset");

    // Back-to-back: second start in the first IDLE cycle after DONE.
    mul(10, 20, "b2b_first");
    first_done = last_done_cyc;
    mul(15, 17, "b2b_second");
    check("b2b_spacing", 32'(last_done_cyc - first_done), 32'(DS + 2));

    for (int i = 0; i < 20; i++) begin
      mul(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
